vend_ctrl_multi: RTL and testbench

Parametrised multi-item vending controller. Generalises the fixed four-item machine:
- any number of items, with per-item prices supplied on a port;
- per-item stock counters with restock;
- saturating credit, an inactivity timeout and overpay-coin rejection.

It sits between the coin acceptor / keypad front end and the dispenser / coin-return actuators. All outputs are registered.

---
 rtl/vend_pkg.sv | 27 ++
 rtl/vend_stock.sv | 42 ++++
 rtl/vend_ctrl_multi.sv | 177 +++++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-item vending controller.
// Pure declarations; no state, no latency, no backpressure.
package vend_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

    localparam int COIN1_VAL = 1;
    localparam int COIN2_VAL = 2;
    localparam int MAX_ITEMS = 16;

    typedef struct packed {
        logic       ok;
        logic [3:0] idx;
    } onehot_t;

    // ok only when exactly one bit is set; idx is that bit's position
    function automatic onehot_t onehot_enc(input logic [MAX_ITEMS-1:0] v);
        onehot_t r;
        r.ok  = (v != '0) && ((v & (v - 16'd1)) == '0);
        r.idx = '0;
        for (int i = 0; i < MAX_ITEMS; i++) begin
            if (v[i]) r.idx = i[3:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-item saturating stock counters with restock and single-item decrement.
// Counters update one edge after restock/dec; empty is combinational from state; never stalls.
module vend_stock #(
    parameter int N_ITEMS = 4,
    parameter int STOCK_W = 4,
    parameter int IDX_W   = $clog2(N_ITEMS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rs_valid,
    input  logic [IDX_W-1:0]   rs_idx,
    input  logic [STOCK_W-1:0] rs_qty,
    input  logic               dec,
    input  logic [IDX_W-1:0]   dec_idx,
    output logic [N_ITEMS-1:0] empty
);

    localparam logic [STOCK_W:0] SAT = {1'b0, {STOCK_W{1'b1}}};

    logic [STOCK_W-1:0] stock [N_ITEMS];

    for (genvar g = 0; g < N_ITEMS; g++) begin : g_item
        logic [STOCK_W:0] sum;
        logic [STOCK_W:0] net;

        // add then subtract in one wider value so restock+vend on one item nets correctly
        always_comb begin
            sum = {1'b0, stock[g]};
            if (rs_valid && rs_idx == IDX_W'(g)) sum = sum + {1'b0, rs_qty};
            net = sum;
            if (dec && dec_idx == IDX_W'(g) && sum != '0) net = sum - 1'b1;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) stock[g] <= '0;
            else      stock[g] <= (net > SAT) ? SAT[STOCK_W-1:0] : net[STOCK_W-1:0];
        end

        assign empty[g] = (stock[g] == '0);
    end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending FSM: selection, coin collection with saturation guard, vend/refund, timeout.
// Selection/coins registered in one edge; vend pulse one edge after credit covers price; refund one edge after REFUND.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int N_ITEMS     = 4,
    parameter int CREDIT_W    = 4,
    parameter int STOCK_W     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_ITEMS-1:0]            sel,
    input  logic [N_ITEMS*CREDIT_W-1:0]   price,
    input  logic                          coin1,
    input  logic                          coin2,
    input  logic                          cnl,
    input  logic                          rs_valid,
    input  logic [$clog2(N_ITEMS)-1:0]    rs_idx,
    input  logic [STOCK_W-1:0]            rs_qty,
    output logic                          vend_valid,
    output logic [$clog2(N_ITEMS)-1:0]    vend_idx,
    output logic [CREDIT_W-1:0]           change,
    output logic                          refund_valid,
    output logic [CREDIT_W-1:0]           refund,
    output logic                          coin_reject,
    output logic                          sel_err,
    output logic                          busy,
    output logic [N_ITEMS-1:0]            empty
);

    localparam int IDX_W = $clog2(N_ITEMS);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit, credit_nxt;
    logic [CREDIT_W-1:0] price_q, price_nxt;
    logic [IDX_W-1:0]    idx_q, idx_nxt;
    logic [TMR_W-1:0]    tmr, tmr_nxt;

    logic                vend_valid_nxt, refund_valid_nxt, coin_reject_nxt, sel_err_nxt;
    logic [IDX_W-1:0]    vend_idx_nxt;
    logic [CREDIT_W-1:0] change_nxt, refund_nxt;
    logic                dec;

    onehot_t             oh;
    logic [IDX_W-1:0]    sel_idx;
    logic [CREDIT_W-1:0] sel_price;
    logic                coin_any, coin_ok;
    logic [CREDIT_W:0]   coin_val, credit_sum;

    assign oh        = onehot_enc(MAX_ITEMS'(sel));
    assign sel_idx   = oh.idx[IDX_W-1:0];
    assign sel_price = price[int'(sel_idx)*CREDIT_W +: CREDIT_W];

    assign coin_any   = coin1 | coin2;
    assign coin_val   = coin2 ? (CREDIT_W+1)'(COIN2_VAL) : (CREDIT_W+1)'(COIN1_VAL);
    assign credit_sum = {1'b0, credit} + coin_val;
    // simultaneous coins or an overflowing coin are both returned
    assign coin_ok    = coin_any && !(coin1 && coin2) && !credit_sum[CREDIT_W];

    always_comb begin
        state_nxt        = state;
        credit_nxt       = credit;
        price_nxt        = price_q;
        idx_nxt          = idx_q;
        tmr_nxt          = tmr;
        vend_valid_nxt   = 1'b0;
        vend_idx_nxt     = '0;
        change_nxt       = '0;
        refund_valid_nxt = 1'b0;
        refund_nxt       = '0;
        coin_reject_nxt  = 1'b0;
        sel_err_nxt      = 1'b0;
        dec              = 1'b0;
        case (state)
            IDLE: begin
                credit_nxt      = '0;
                coin_reject_nxt = coin_any;
                if (sel != '0) begin
                    if (!oh.ok || empty[sel_idx]) begin
                        sel_err_nxt = 1'b1;
                    end else begin
                        idx_nxt   = sel_idx;
                        price_nxt = sel_price;
                        tmr_nxt   = '0;
                        state_nxt = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (cnl) begin
                    coin_reject_nxt = coin_any;
                    state_nxt       = REFUND;
                end else if (credit >= price_q) begin
                    coin_reject_nxt = coin_any;
                    vend_valid_nxt  = 1'b1;
                    vend_idx_nxt    = idx_q;
                    change_nxt      = credit - price_q;
                    dec             = 1'b1;
                    state_nxt       = VEND;
                end else begin
                    coin_reject_nxt = coin_any && !coin_ok;
                    if (coin_ok) begin
                        credit_nxt = credit_sum[CREDIT_W-1:0];
                        tmr_nxt    = '0;
                    end else if (tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
                        state_nxt = REFUND;
                    end else begin
                        tmr_nxt = tmr + TMR_W'(1);
                    end
                end
            end
            VEND: begin
                coin_reject_nxt = coin_any;
                credit_nxt      = '0;
                state_nxt       = IDLE;
            end
            REFUND: begin
                coin_reject_nxt  = coin_any;
                refund_valid_nxt = 1'b1;
                refund_nxt       = credit;
                credit_nxt       = '0;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            credit       <= '0;
            price_q      <= '0;
            idx_q        <= '0;
            tmr          <= '0;
            vend_valid   <= 1'b0;
            vend_idx     <= '0;
            change       <= '0;
            refund_valid <= 1'b0;
            refund       <= '0;
            coin_reject  <= 1'b0;
            sel_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            credit       <= credit_nxt;
            price_q      <= price_nxt;
            idx_q        <= idx_nxt;
            tmr          <= tmr_nxt;
            vend_valid   <= vend_valid_nxt;
            vend_idx     <= vend_idx_nxt;
            change       <= change_nxt;
            refund_valid <= refund_valid_nxt;
            refund       <= refund_nxt;
            coin_reject  <= coin_reject_nxt;
            sel_err      <= sel_err_nxt;
        end
    end

    assign busy = (state != IDLE);

    vend_stock #(
        .N_ITEMS (N_ITEMS),
        .STOCK_W (STOCK_W),
        .IDX_W   (IDX_W)
    ) u_stock (
        .clk      (clk),
        .rst      (rst),
        .rs_valid (rs_valid),
        .rs_idx   (rs_idx),
        .rs_qty   (rs_qty),
        .dec      (dec),
        .dec_idx  (idx_q),
        .empty    (empty)
    );

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi: cycle-by-cycle vector table plus a hand-written mid-transaction reset.
module tb_vend_ctrl_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sel;
    logic [15:0] price;
    logic        coin1, coin2, cnl, rs_valid;
    logic [1:0]  rs_idx;
    logic [3:0]  rs_qty;
    logic        vend_valid, refund_valid, coin_reject, sel_err, busy;
    logic [1:0]  vend_idx;
    logic [3:0]  change, refund, empty;

    always #5 clk = ~clk;

    vend_ctrl_multi #(
        .N_ITEMS(4), .CREDIT_W(4), .STOCK_W(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .sel(sel), .price(price),
        .coin1(coin1), .coin2(coin2), .cnl(cnl),
        .rs_valid(rs_valid), .rs_idx(rs_idx), .rs_qty(rs_qty),
        .vend_valid(vend_valid), .vend_idx(vend_idx), .change(change),
        .refund_valid(refund_valid), .refund(refund),
        .coin_reject(coin_reject), .sel_err(sel_err), .busy(busy), .empty(empty)
    );

    typedef struct packed {
        logic [3:0] sel;
        logic       c1, c2, cn, rsv;
        logic [1:0] rsi;
        logic [3:0] rsq;
    } in_t;

    typedef struct packed {
        logic       vv;
        logic [1:0] vi;
        logic [3:0] chg;
        logic       rv;
        logic [3:0] rf;
        logic       cr, se, bz;
        logic [3:0] emp;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic in_t mk_in(logic [3:0] s, logic c1, logic c2, logic cn,
                                  logic rsv, logic [1:0] rsi, logic [3:0] rsq);
        in_t r;
        r.sel = s; r.c1 = c1; r.c2 = c2; r.cn = cn; r.rsv = rsv; r.rsi = rsi; r.rsq = rsq;
        return r;
    endfunction

    function automatic out_t mk_out(logic vv, logic [1:0] vi, logic [3:0] chg, logic rv,
                                    logic [3:0] rf, logic cr, logic se, logic bz, logic [3:0] emp);
        out_t r;
        r.vv = vv; r.vi = vi; r.chg = chg; r.rv = rv; r.rf = rf;
        r.cr = cr; r.se = se; r.bz = bz; r.emp = emp;
        return r;
    endfunction

    function automatic out_t oi(logic [3:0] emp);
        return mk_out(0, 0, 0, 0, 0, 0, 0, 0, emp);
    endfunction

    function automatic out_t ob(logic [3:0] emp);
        return mk_out(0, 0, 0, 0, 0, 0, 0, 1, emp);
    endfunction

    function automatic string fmt(out_t o);
        return $sformatf("vv=%0b vi=%0d chg=%0d rv=%0b rf=%0d cr=%0b se=%0b busy=%0b empty=%b",
                         o.vv, o.vi, o.chg, o.rv, o.rf, o.cr, o.se, o.bz, o.emp);
    endfunction

    function automatic out_t sample();
        return mk_out(vend_valid, vend_idx, change, refund_valid, refund,
                      coin_reject, sel_err, busy, empty);
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %s / want %s", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.i = i; v.o = o;
        vecs.push_back(v);
    endtask

    task automatic drive(input in_t i);
        sel = i.sel; coin1 = i.c1; coin2 = i.c2; cnl = i.cn;
        rs_valid = i.rsv; rs_idx = i.rsi; rs_qty = i.rsq;
    endtask

    initial begin
        in_t nop, ic1, ic2;
        nop = mk_in(0, 0, 0, 0, 0, 0, 0);
        ic1 = mk_in(0, 1, 0, 0, 0, 0, 0);
        ic2 = mk_in(0, 0, 1, 0, 0, 0, 0);

        // item3=6, item2=15, item1=0, item0=3
        price = {4'd6, 4'd15, 4'd0, 4'd3};

        // stock all 3
        add(mk_in(0, 0, 0, 0, 1, 0, 3), oi(4'b1110));
        add(mk_in(0, 0, 0, 0, 1, 1, 3), oi(4'b1100));
        add(mk_in(0, 0, 0, 0, 1, 2, 3), oi(4'b1000));
        add(mk_in(0, 0, 0, 0, 1, 3, 3), oi(4'b0000));
        // item0, price 3, two coin2 -> change 1
        add(mk_in(4'b0001, 0, 0, 0, 0, 0, 0), ob(0));
        add(ic2, ob(0));
        add(ic2, ob(0));
        add(nop, mk_out(1, 0, 1, 0, 0, 0, 0, 1, 0));
        add(nop, oi(0));
        // saturating restock of item2
        add(mk_in(0, 0, 0, 0, 1, 2, 15), oi(0));
        add(mk_in(0, 0, 0, 0, 1, 2, 15), oi(0));
        // item1 at price 0, drained to sold out
        for (int k = 0; k < 3; k++) begin
            add(mk_in(4'b0010, 0, 0, 0, 0, 0, 0), ob(0));
            add(nop, mk_out(1, 1, 0, 0, 0, 0, 0, 1, (k == 2) ? 4'b0010 : 4'b0000));
            add(nop, oi((k == 2) ? 4'b0010 : 4'b0000));
        end
        add(mk_in(4'b0010, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 1, 0, 4'b0010));
        add(nop, oi(4'b0010));
        add(mk_in(4'b0011, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 1, 0, 4'b0010));
        add(nop, oi(4'b0010));
        // restock and vend of item1 on the same edge
        add(mk_in(0, 0, 0, 0, 1, 1, 1), oi(0));
        add(mk_in(4'b0010, 0, 0, 0, 0, 0, 0), ob(0));
        add(mk_in(0, 0, 0, 0, 1, 1, 1), mk_out(1, 1, 0, 0, 0, 0, 0, 1, 0));
        add(nop, oi(0));
        add(mk_in(4'b0010, 0, 0, 0, 0, 0, 0), ob(0));
        add(nop, mk_out(1, 1, 0, 0, 0, 0, 0, 1, 4'b0010));
        add(nop, oi(4'b0010));
        // item3: coin2 then cancel with coin1 -> refund 2, coin returned
        add(mk_in(4'b1000, 0, 0, 0, 0, 0, 0), ob(4'b0010));
        add(ic2, ob(4'b0010));
        add(mk_in(0, 1, 0, 1, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 1, 0, 1, 4'b0010));
        add(nop, mk_out(0, 0, 0, 1, 2, 0, 0, 0, 4'b0010));
        add(nop, oi(4'b0010));
        // both coins together are both rejected; zero refund still pulses
        add(mk_in(4'b1000, 0, 0, 0, 0, 0, 0), ob(4'b0010));
        add(mk_in(0, 1, 1, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 1, 0, 1, 4'b0010));
        add(mk_in(0, 0, 0, 1, 0, 0, 0), ob(4'b0010));
        add(nop, mk_out(0, 0, 0, 1, 0, 0, 0, 0, 4'b0010));
        add(nop, oi(4'b0010));
        // timeout: refund 9 cycles after the last accepted coin
        add(mk_in(4'b1000, 0, 0, 0, 0, 0, 0), ob(4'b0010));
        add(ic1, ob(4'b0010));
        for (int k = 0; k < 8; k++) add(nop, ob(4'b0010));
        add(nop, mk_out(0, 0, 0, 1, 1, 0, 0, 0, 4'b0010));
        add(nop, oi(4'b0010));
        // item2 at price 15: overflow coin rejected at 14, coin1 completes
        add(mk_in(4'b0100, 0, 0, 0, 0, 0, 0), ob(4'b0010));
        for (int k = 0; k < 7; k++) add(ic2, ob(4'b0010));
        add(ic2, mk_out(0, 0, 0, 0, 0, 1, 0, 1, 4'b0010));
        add(ic1, ob(4'b0010));
        add(nop, mk_out(1, 2, 0, 0, 0, 0, 0, 1, 4'b0010));
        add(nop, oi(4'b0010));

        // reset state
        rst = 1'b0;
        drive(nop);
        #1;
        check("reset_async", sample(), oi(4'b1111));
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", sample(), oi(4'b1111));
        rst = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].i);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", k), sample(), vecs[k].o);
        end

        // reset while collecting credit on item0
        drive(mk_in(4'b0001, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        check("rst_seq_sel", sample(), ob(4'b0010));
        drive(ic2);
        @(posedge clk); #1;
        check("rst_seq_coin", sample(), ob(4'b0010));
        drive(nop);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_collect", sample(), oi(4'b1111));
        @(posedge clk); #1;
        check("rst_mid_held", sample(), oi(4'b1111));
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst_no_refund%0d", k), sample(), oi(4'b1111));
        end
        drive(mk_in(4'b0001, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        check("rst_stock_cleared", sample(), mk_out(0, 0, 0, 0, 0, 0, 1, 0, 4'b1111));
        drive(nop);
        @(posedge clk); #1;
        check("rst_final_idle", sample(), oi(4'b1111));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
